// File: rtl/uart_pkg.sv
// Shared UART types: transmit FSM states, per-frame configuration, line levels.
package uart_pkg;

    // Widest supported bit-period divisor; the frame config stores the divisor at this width.
    localparam int unsigned UART_DIV_W = 16;

    // Level driven on the serial line whenever no frame is in flight.
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    typedef struct packed {
        logic [UART_DIV_W-1:0] div;
        logic                  parity_en;
        logic                  parity_odd;
        logic                  stop2;
    } uart_frame_cfg_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter marking the last clock of a bit period.
module uart_bit_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         bit_end
);

    logic [W-1:0] count;

    // Reload at each bit start, otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign bit_end = (count == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: fetches one FIFO word per frame and shifts it out
// as start, data (LSB first), optional parity and one or two stop bits.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_baud_div,
    input  logic             i_parity_en,
    input  logic             i_parity_odd,
    input  logic             i_stop2,
    input  logic             i_fifo_empty,
    input  logic             i_fifo_valid,
    input  logic [DW-1:0]    i_fifo_data,
    input  logic             i_fifo_parity_error,
    output logic             o_fifo_rd_req,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_drop
);

    localparam int unsigned CNT_W = (DW > 1) ? $clog2(DW) : 1;

    uart_tx_state_t  state, state_next;
    uart_frame_cfg_t cfg;
    logic [DW-1:0]    shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic             stop_cnt;
    logic             parity_bit;

    logic             tx_next, done_next, drop_next;
    logic             latch, load, shift, cnt_inc, stop_inc;
    logic             bit_end;
    logic [DIV_W-1:0] load_val;

    // The first bit period is loaded straight from the input, in the same cycle the config is latched.
    assign load_val = (state == ST_WAIT) ? i_baud_div : DIV_W'(cfg.div);

    uart_bit_timer #(.W(DIV_W)) u_bit_timer (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (load),
        .load_val (load_val),
        .bit_end  (bit_end)
    );

    assign o_busy        = (state != ST_IDLE);
    assign o_fifo_rd_req = (state == ST_REQ);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, next line level and datapath controls.
    always_comb begin
        state_next = state;
        tx_next    = o_tx;
        done_next  = 1'b0;
        drop_next  = 1'b0;
        latch      = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        cnt_inc    = 1'b0;
        stop_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_enable && !i_fifo_empty) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_fifo_valid) begin
                    if (i_fifo_parity_error) begin
                        drop_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        latch      = 1'b1;
                        load       = 1'b1;
                        tx_next    = 1'b0;
                        state_next = ST_START;
                    end
                end
            end
            ST_START: begin
                if (bit_end) begin
                    load       = 1'b1;
                    shift      = 1'b1;
                    tx_next    = shreg[0];
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    load = 1'b1;
                    if (bit_cnt == CNT_W'(DW - 1)) begin
                        if (cfg.parity_en) begin
                            tx_next    = parity_bit;
                            state_next = ST_PARITY;
                        end else begin
                            tx_next    = UART_IDLE_LEVEL;
                            state_next = ST_STOP;
                        end
                    end else begin
                        tx_next = shreg[0];
                        shift   = 1'b1;
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    load       = 1'b1;
                    tx_next    = UART_IDLE_LEVEL;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (cfg.stop2 && !stop_cnt) begin
                        load     = 1'b1;
                        stop_inc = 1'b1;
                    end else begin
                        done_next  = 1'b1;
                        state_next = (i_enable && !i_fifo_empty) ? ST_REQ : ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, frame config, shift register and bit/stop counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_tx         <= UART_IDLE_LEVEL;
            o_frame_done <= 1'b0;
            o_drop       <= 1'b0;
            cfg          <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            parity_bit   <= 1'b0;
        end else begin
            o_tx         <= tx_next;
            o_frame_done <= done_next;
            o_drop       <= drop_next;
            if (latch) begin
                cfg        <= '{div:        UART_DIV_W'(i_baud_div),
                                parity_en:  i_parity_en,
                                parity_odd: i_parity_odd,
                                stop2:      i_stop2};
                shreg      <= i_fifo_data;
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                parity_bit <= (^i_fifo_data) ^ i_parity_odd;
            end
            if (shift) begin
                shreg <= shreg >> 1;
            end
            if (cnt_inc) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (stop_inc) begin
                stop_cnt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: behavioural FIFO plus a bit-list line model.
module tb_uart_tx_engine;

    localparam int unsigned DW    = 8;
    localparam int unsigned DIV_W = 16;

    typedef struct {
        logic [DW-1:0] data;
        bit            perr;
    } word_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [DIV_W-1:0] baud_div;
    logic             parity_en;
    logic             parity_odd;
    logic             stop2;
    logic             fifo_empty;
    logic             fifo_valid;
    logic [DW-1:0]    fifo_data;
    logic             fifo_perr;
    logic             rd_req;
    logic             tx;
    logic             busy;
    logic             done;
    logic             drop;

    word_t fq[$];

    int n_cmp    = 0;
    int n_bad    = 0;
    int rd_cnt   = 0;
    int drop_cnt = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    logic [1:0] rd_hist = '0;

    uart_tx_engine #(.DW(DW), .DIV_W(DIV_W)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_enable            (enable),
        .i_baud_div          (baud_div),
        .i_parity_en         (parity_en),
        .i_parity_odd        (parity_odd),
        .i_stop2             (stop2),
        .i_fifo_empty        (fifo_empty),
        .i_fifo_valid        (fifo_valid),
        .i_fifo_data         (fifo_data),
        .i_fifo_parity_error (fifo_perr),
        .o_fifo_rd_req       (rd_req),
        .o_tx                (tx),
        .o_busy              (busy),
        .o_frame_done        (done),
        .o_drop              (drop)
    );

    always #5 clk = ~clk;

    // Event counters and read-request history, updated on the active edge.
    always @(posedge clk) begin
        rd_hist  <= {rd_hist[0], (rd_req === 1'b1)};
        rd_cnt   <= rd_cnt + ((rd_req === 1'b1) ? 1 : 0);
        drop_cnt <= drop_cnt + ((drop === 1'b1) ? 1 : 0);
        done_cnt <= done_cnt + ((done === 1'b1) ? 1 : 0);
        if (done === 1'b1 && drop === 1'b1) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input bit perr);
        word_t w;
        w.data = d;
        w.perr = perr;
        fq.push_back(w);
    endtask

    task automatic set_cfg(input int div, input bit pen, input bit podd, input bit s2);
        baud_div   = DIV_W'(div);
        parity_en  = pen;
        parity_odd = podd;
        stop2      = s2;
    endtask

    // Behavioural read port: valid with data the cycle after an accepted read.
    initial begin
        word_t w;
        fifo_valid = 1'b0;
        fifo_data  = '0;
        fifo_perr  = 1'b0;
        fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (rd_req === 1'b1 && fq.size() > 0) begin
                w = fq.pop_front();
                fifo_empty = (fq.size() == 0);
                @(posedge clk);
                #1;
                fifo_valid = 1'b1;
                fifo_data  = w.data;
                fifo_perr  = w.perr;
                @(posedge clk);
                #1;
                fifo_valid = 1'b0;
                fifo_perr  = 1'b0;
                fifo_data  = DW'($urandom);
            end else begin
                fifo_empty = (fq.size() == 0);
            end
        end
    end

    // Waits for the start bit, then compares every clock of the frame with the
    // expected bit list and checks the frame_done pulse that follows it.
    task automatic expect_frame(input logic [DW-1:0] data, input int div, input bit pen,
                                input bit podd, input bit s2, input bit scramble,
                                input int en_off_at, output int hi);
        bit bits[$];
        bit started;
        int len;
        bits = {};
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(bit'($countones(data) % 2) ^ podd);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        len = bits.size() * (div + 1);
        hi = 0;
        started = 1'b0;
        for (int g = 0; g < 400 && !started; g++) begin
            @(negedge clk);
            if (tx === 1'b0) started = 1'b1;
            else hi++;
        end
        check("start_seen", 32'(started), 32'd1);
        if (!started) return;
        check("req_to_start", 32'(rd_hist), 32'b10);
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            if (scramble && c == div + 1) begin
                baud_div   = DIV_W'($urandom_range(0, 7));
                parity_en  = 1'($urandom);
                parity_odd = 1'($urandom);
                stop2      = 1'($urandom);
            end
            if (c == en_off_at) enable = 1'b0;
            check($sformatf("tx_bit%0d_clk%0d", c / (div + 1), c), 32'(tx), 32'(bits[c / (div + 1)]));
            check("busy_in_frame", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
        end
        @(negedge clk);
        check("frame_done", 32'(done), 32'd1);
        check("tx_idle_after", 32'(tx), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, r0, d0, n0;
        int div;
        bit pen, podd, s2, bad;
        logic [DW-1:0] d;
        bit ok;

        rst = 1'b1;
        enable = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 8N1, div=3: 40-clock frame, single read request.
        set_cfg(3, 0, 0, 0);
        r0 = rd_cnt;
        push(8'h55, 0);
        enable = 1'b1;
        expect_frame(8'h55, 3, 0, 0, 0, 0, -1, hi);
        repeat (5) @(negedge clk);
        check("8n1_rd_pulses", 32'(rd_cnt - r0), 32'd1);
        check("8n1_idle_busy", 32'(busy), 32'd0);

        // Parity bit values.
        set_cfg(1, 1, 0, 0);
        push(8'h07, 0);
        expect_frame(8'h07, 1, 1, 0, 0, 0, -1, hi);
        set_cfg(1, 1, 1, 0);
        push(8'h07, 0);
        expect_frame(8'h07, 1, 1, 1, 0, 0, -1, hi);
        set_cfg(1, 1, 0, 0);
        push(8'h00, 0);
        expect_frame(8'h00, 1, 1, 0, 0, 0, -1, hi);

        // Two stop bits, div=0, back-to-back frames.
        set_cfg(0, 0, 0, 1);
        r0 = rd_cnt;
        push(8'hA5, 0);
        push(8'h3C, 0);
        expect_frame(8'hA5, 0, 0, 0, 1, 0, -1, hi);
        expect_frame(8'h3C, 0, 0, 0, 1, 0, -1, hi);
        check("b2b_gap_high_cycles", 32'(hi + 1), 32'd2);
        repeat (5) @(negedge clk);
        check("b2b_rd_pulses", 32'(rd_cnt - r0), 32'd2);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Parity-error word is dropped, the next one transmits.
        set_cfg(2, 1, 0, 0);
        d0 = drop_cnt;
        push(8'hC3, 1);
        push(8'h5A, 0);
        expect_frame(8'h5A, 2, 1, 0, 0, 0, -1, hi);
        check("drop_pulses", 32'(drop_cnt - d0), 32'd1);

        // Reset during DATA.
        set_cfg(2, 0, 0, 0);
        push(8'h0F, 0);
        ok = 1'b0;
        for (int g = 0; g < 200 && !ok; g++) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1'b1;
        end
        check("rst_mid_start_seen", 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        n0 = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt - n0), 32'd0);
        check("rst_mid_tx_idle", 32'(tx), 32'd1);

        // Enable dropped during DATA: frame completes, no further request.
        set_cfg(1, 0, 0, 0);
        r0 = rd_cnt;
        push(8'h81, 0);
        push(8'h42, 0);
        expect_frame(8'h81, 1, 0, 0, 0, 0, 6, hi);
        repeat (20) @(negedge clk);
        check("en_off_rd_pulses", 32'(rd_cnt - r0), 32'd1);
        check("en_off_busy", 32'(busy), 32'd0);
        check("en_off_tx", 32'(tx), 32'd1);
        enable = 1'b1;
        expect_frame(8'h42, 1, 0, 0, 0, 0, -1, hi);

        // Randomized frames with mid-frame config changes and occasional drops.
        for (int n = 0; n < 30; n++) begin
            div  = $urandom_range(0, 4);
            pen  = 1'($urandom);
            podd = 1'($urandom);
            s2   = 1'($urandom);
            bad  = ($urandom_range(0, 5) == 0);
            d    = DW'($urandom);
            set_cfg(div, pen, podd, s2);
            d0 = drop_cnt;
            if (bad) push(DW'($urandom), 1);
            push(d, 0);
            expect_frame(d, div, pen, podd, s2, 1, -1, hi);
            check("rand_drop_count", 32'(drop_cnt - d0), 32'(bad));
        end

        repeat (3) @(negedge clk);
        check("done_drop_overlap", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

UART transmit serializer that drains the TX FIFO (`uart_fifo`) from its read port and drives the serial line. It sits between the TX FIFO and the `o_tx` pad. It fetches one word per frame using the FIFO's `rd_req`/`valid` handshake, then emits start, data, optional parity and 1 or 2 stop bits at a programmable bit period. It discards words that the FIFO flags with a parity error.

## Interface
Parameters:
- `DW`, 8 — data bits per frame, LSB first; must match the FIFO `FIFO_DW`.
- `DIV_W`, 16 — width of the bit-period divisor.

Ports:
- `i_clk` in 1 — system clock.
- `i_rst` in 1 — reset; one clock, synchronous, active-high.
- `i_enable` in 1 — permits starting new frames.
- `i_baud_div` in DIV_W — bit period is `i_baud_div+1` clocks; sampled at frame start.
- `i_parity_en` in 1 — insert a parity bit; sampled at frame start.
- `i_parity_odd` in 1 — 1 selects odd parity, 0 selects even; sampled at frame start.
- `i_stop2` in 1 — 1 selects two stop bits, 0 selects one; sampled at frame start.
- `i_fifo_empty` in 1 — FIFO empty flag.
- `i_fifo_valid` in 1 — FIFO read data valid, one cycle after an accepted read.
- `i_fifo_data` in DW — FIFO read data.
- `i_fifo_parity_error` in 1 — FIFO storage parity error, qualified by `i_fifo_valid`.
- `o_fifo_rd_req` out 1 — single-cycle read request.
- `o_tx` out 1 — serial line; idles high.
- `o_busy` out 1 — high in every state except IDLE.
- `o_frame_done` out 1 — one-cycle pulse at the end of the last stop bit.
- `o_drop` out 1 — one-cycle pulse when a fetched word is discarded for a parity error.

## Operation
- States: IDLE, REQ, WAIT, START, DATA, PARITY, STOP.
- IDLE → REQ when `i_enable && !i_fifo_empty`.
- REQ: `o_fifo_rd_req=1` for exactly one cycle (decoded from state), then → WAIT.
- WAIT: hold until `i_fifo_valid`.
  - On valid, latch data and the frame config (div, parity_en, parity_odd, stop2).
  - If `i_fifo_parity_error`: pulse `o_drop` and → IDLE.
  - Otherwise → START.
- START: line 0 for one bit period.
- DATA: DW bits, LSB first; bit counter 0..DW-1.
- PARITY: entered only if latched `parity_en`.
  - Bit value = XOR of the data bits, XOR `parity_odd`.
- STOP: line 1 for 1 or 2 bit periods.
  - At the end of the last stop bit, pulse `o_frame_done`.
  - Then → REQ if `i_enable && !i_fifo_empty`, else → IDLE.
- Bit timer: loads the latched div at each bit start and counts down to 0.
  - The bit ends on the cycle the count is 0.
  - div=0 gives a one-clock bit.
- `i_enable` falling mid-frame: the current frame completes; no new REQ is issued.
- Config inputs changing mid-frame have no effect until the next frame.
- Reset: `o_tx=1`, `o_busy=0`, `o_fifo_rd_req=0`, `o_frame_done=0`, `o_drop=0`. The state goes to IDLE and the timer and counters clear.
- Reset mid-frame: line returns high on the next edge, and the in-flight word is lost.
- If `i_fifo_valid` never arrives, the engine stays in WAIT. No timeout; the FIFO guarantees valid on a non-empty read.

## Timing
- All outputs are registered, except `o_fifo_rd_req` and `o_busy`, which are decoded from the state register.
- Edge k samples `i_enable && !empty` → REQ in cycle k+1 → FIFO valid in k+2 → `o_tx` low from k+3.
- Frame length = (1 + DW + parity_en + 1 + stop2) × (div+1) clocks.
- Back-to-back frames: 2 idle-high cycles (REQ, WAIT) between the last stop bit and the next start bit.
- `o_frame_done` and `o_drop` are never both high in the same cycle.

## Structure
- In `uart_pkg`:
  - `uart_tx_state_t` enum.
  - `uart_frame_cfg_t` packed struct {div, parity_en, parity_odd, stop2}.
  - Localparam for the idle line level.
- Sub-module: `uart_bit_timer` — loadable down-counter with a `bit_end` output. The same counter is reused by the future receiver at half-bit offset.
- The top-level FSM, shift register and bit counter stay in `uart_tx_engine`.

## Test plan
- **8N1 data:** 0x55, div=3, parity off, stop1.
  - `o_tx` = 0,1,0,1,0,1,0,1,0,1, 4 clocks per bit.
  - `o_frame_done` pulses 40 clocks after the start bit.
  - One `o_fifo_rd_req` pulse for the frame.
- **Parity bit:** 0x07 with even parity → parity bit 1; with odd parity → parity bit 0. 0x00 with even parity → parity bit 0.
- **Two stop bits, back-to-back:** `i_stop2=1`, div=0, FIFO holding 0xA5 then 0x3C.
  - Two frames of 11 clocks each.
  - Exactly 2 high cycles between the frames.
  - 2 `o_fifo_rd_req` pulses, then IDLE with `o_busy=0`.
- **Parity-error drop:** fetched word has `i_fifo_parity_error=1`.
  - `o_drop` pulses once and `o_tx` stays high.
  - The next word transmits normally.
- **Reset and enable mid-frame:**
  - `i_rst` asserted during DATA → `o_tx=1`, `o_busy=0` on the next edge, and no `o_frame_done`.
  - `i_enable` dropped during DATA → the frame finishes, and no further `o_fifo_rd_req` is issued although the FIFO is non-empty.
